// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: owns the power-on init of an 8-bit character LCD, then
// passes the upstream RS/RW/DATA byte stream onto the bus, one byte per slot.
// Every slot latches the bus at ph=0, pulses LCD_E during ph 1..E_HIGH for
// writes, and holds the bus through ph SLOT-1. BYTE_STB at ph=SLOT-2 tells the
// formatters to advance, so their next byte is stable before the next wrap.
module lcd_bus_driver #(
  parameter int SLOT     = 8,
  parameter int E_HIGH   = 3,
  parameter int PWR_WAIT = 20000,
  parameter int CLR_WAIT = 400
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RW_IN,
  input  logic       RS_IN,
  input  logic [7:0] DATA_IN,
  output logic       BYTE_STB,
  output logic       READY,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  // One width covers the power-up wait, the clear wait and the slot phase.
  localparam int MAXV = (PWR_WAIT > CLR_WAIT) ?
                        ((PWR_WAIT > SLOT) ? PWR_WAIT : SLOT) :
                        ((CLR_WAIT > SLOT) ? CLR_WAIT : SLOT);
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;

  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    FUNC      = 3'd1,
    DISP      = 3'd2,
    ENTRY     = 3'd3,
    CLEAR     = 3'd4,
    CLR_HOLD  = 3'd5,
    RUN       = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ph_q, ph_d;
  logic [CW-1:0] ph_next;
  logic          ph_wrap;
  logic          rs_q, rs_d;
  logic          rw_q, rw_d;
  logic [7:0]    data_q, data_d;
  logic          e_q, e_d;
  logic          stb_q, stb_d;
  logic          ready_q, ready_d;

  // States in which the slot phase counter runs and LCD_E may pulse.
  function automatic logic in_slot(input state_t s);
    logic r;
    case (s)
      FUNC, DISP, ENTRY, CLEAR, RUN: r = 1'b1;
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

  // Next-state, slot phase and next-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    data_d  = data_q;
    ph_wrap = (ph_q == CW'(SLOT - 1));
    if (ph_wrap) begin
      ph_next = {CW{1'b0}};
    end else begin
      ph_next = ph_q + CW'(1);
    end

    case (state_q)
      INIT_WAIT: begin
        if (cnt_q == CW'(PWR_WAIT - 1)) begin
          cnt_d   = {CW{1'b0}};
          ph_d    = {CW{1'b0}};
          state_d = FUNC;
          rs_d    = 1'b0;
          rw_d    = 1'b0;
          data_d  = 8'h38;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FUNC: begin
        ph_d = ph_next;
        if (ph_wrap) begin
          state_d = DISP;
          rs_d    = 1'b0;
          rw_d    = 1'b0;
          data_d  = 8'h0C;
        end else begin
          state_d = FUNC;
        end
      end
      DISP: begin
        ph_d = ph_next;
        if (ph_wrap) begin
          state_d = ENTRY;
          rs_d    = 1'b0;
          rw_d    = 1'b0;
          data_d  = 8'h06;
        end else begin
          state_d = DISP;
        end
      end
      ENTRY: begin
        ph_d = ph_next;
        if (ph_wrap) begin
          state_d = CLEAR;
          rs_d    = 1'b0;
          rw_d    = 1'b0;
          data_d  = 8'h01;
        end else begin
          state_d = ENTRY;
        end
      end
      CLEAR: begin
        // The Clear command stays on the bus while the LCD finishes clearing.
        ph_d = ph_next;
        if (ph_wrap) begin
          state_d = CLR_HOLD;
        end else begin
          state_d = CLEAR;
        end
      end
      CLR_HOLD: begin
        if (cnt_q == CW'(CLR_WAIT - 1)) begin
          cnt_d   = {CW{1'b0}};
          ph_d    = {CW{1'b0}};
          state_d = RUN;
          rs_d    = RS_IN;
          rw_d    = RW_IN;
          data_d  = DATA_IN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        ph_d = ph_next;
        if (ph_wrap) begin
          rs_d   = RS_IN;
          rw_d   = RW_IN;
          data_d = DATA_IN;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = INIT_WAIT;
        cnt_d   = {CW{1'b0}};
        ph_d    = {CW{1'b0}};
        rs_d    = 1'b0;
        rw_d    = 1'b1;
        data_d  = 8'h00;
      end
    endcase

    e_d     = in_slot(state_d) && (ph_d >= CW'(1)) && (ph_d <= CW'(E_HIGH)) && !rw_d;
    stb_d   = (state_d == RUN) && (ph_d == CW'(SLOT - 2));
    ready_d = (state_d == RUN);
  end

  // State, counters and all registered outputs; reset drops them at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= INIT_WAIT;
      cnt_q   <= {CW{1'b0}};
      ph_q    <= {CW{1'b0}};
      rs_q    <= 1'b0;
      rw_q    <= 1'b1;
      data_q  <= 8'h00;
      e_q     <= 1'b0;
      stb_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      e_q     <= e_d;
      stb_q   <= stb_d;
      ready_q <= ready_d;
    end
  end

  assign LCD_E    = e_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = rw_q;
  assign LCD_DATA = data_q;
  assign BYTE_STB = stb_q;
  assign READY    = ready_q;

endmodule

// File: doc/lcd_bus_driver.md
Name: lcd_bus_driver

Overview:
Sits directly downstream of the per-mode display formatters, after the mode mux. Consumes the RW/RS/DATA character stream those formatters produce and drives the physical 8-bit character-LCD bus.
- Owns the LCD power-on initialisation sequence.
- Generates the LCD_E enable strobe with setup/hold margins.
- Emits BYTE_STB, the advance enable that paces the formatters' character counters: one byte per slot.

Parameters:
SLOT, 8, clock cycles per LCD bus transaction (byte slot); legal range SLOT >= E_HIGH+3.
E_HIGH, 3, cycles LCD_E is held high within a slot.
PWR_WAIT, 20000, cycles waited after reset before the first init command.
CLR_WAIT, 400, extra cycles waited after the Clear Display command.

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
RW_IN  in  1  upstream read/write select; 1 = idle/no write, 0 = write
RS_IN  in  1  upstream register select; 0 = command, 1 = data
DATA_IN  in  8  upstream byte
BYTE_STB  out  1  one-cycle advance pulse to upstream; upstream updates on the edge ending this cycle
READY  out  1  high once initialisation is complete
LCD_E  out  1  LCD enable strobe
LCD_RS  out  1  LCD register select
LCD_RW  out  1  LCD read/write
LCD_DATA  out  8  LCD data bus

Behaviour:
- One clock. RESET is asynchronous and active-high. All outputs are registered.
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=1, LCD_DATA=8'h00, BYTE_STB=0, READY=0, state=INIT_WAIT, all counters 0.
- States, in order:
  - INIT_WAIT: wait PWR_WAIT cycles.
  - FUNC: send 8'h38.
  - DISP: send 8'h0C.
  - ENTRY: send 8'h06.
  - CLEAR: send 8'h01.
  - CLR_HOLD: wait CLR_WAIT cycles.
  - RUN: pass the upstream stream through. RUN is terminal until RESET.
- Slot phase counter ph runs 0..SLOT-1 and wraps. It runs only in FUNC..CLEAR and RUN, and is 0 on entry to each slot.
- Slot timing:
  - At the edge entering ph=0, latch the slot's RS/RW/DATA into LCD_RS/LCD_RW/LCD_DATA. Hold them for the whole slot.
  - LCD_E=1 during ph 1..E_HIGH, only if the latched RW=0. Otherwise LCD_E=0.
  - ph=0 is address/data setup; ph E_HIGH+1..SLOT-1 is hold.
- Init slots (FUNC..CLEAR): latch RS=0, RW=0 and the command byte; inputs are ignored. Each command takes exactly one slot, then the next state is entered at the ph wrap.
- BYTE_STB is 0 in every state except RUN.
- In RUN:
  - BYTE_STB=1 exactly when ph=SLOT-2.
  - Upstream advances at the end of that cycle, so new inputs are stable during ph=SLOT-1 and are latched at the wrap.
  - Inputs sampled on that edge are the ones used for the slot.
  - RW_IN=1: LCD_RW=1, no E pulse, and LCD_RS/LCD_DATA still follow the inputs. The slot still elapses and BYTE_STB still pulses.
- READY:
  - Rises on the edge that leaves CLR_HOLD, which is the same edge that latches the first RUN slot.
  - Latency from RESET deassert is PWR_WAIT + 4*SLOT + CLR_WAIT rising edges.
- Counter widths are sized with $clog2 of the largest of PWR_WAIT, CLR_WAIT and SLOT. Counters must not overflow at the defaults. Terminal compare is equality (count == N-1), then clear.
- Mid-operation reset: outputs go to reset values immediately, including LCD_E dropping mid-pulse, and the full init sequence re-runs.
- Input changes at any ph other than SLOT-1→0 have no effect on the LCD outputs.

Test Plan:
1. Reset and init, with PWR_WAIT=10, SLOT=4, E_HIGH=1, CLR_WAIT=6 (all scenarios use these values): assert RESET then release → LCD_DATA sequence 38, 0C, 06, 01 with LCD_RS=0 and LCD_RW=0. Each command gets one LCD_E pulse of 1 cycle at ph=1. READY=1 exactly 32 edges after release. BYTE_STB stays 0 throughout.
2. RUN pass-through: upstream model advances on BYTE_STB, presenting (RS=0,80), then (1,54), then (1,6F) → LCD_DATA 80, 54, 6F on consecutive 4-cycle slots with matching RS. BYTE_STB pulses every 4 cycles at ph=2.
3. Idle: hold RW_IN=1, DATA_IN=02 → LCD_RW=1, LCD_E stays 0, and BYTE_STB keeps pulsing every 4 cycles.
4. Glitch immunity: change DATA_IN at ph=1 of a slot → LCD_DATA is unchanged until the next wrap.
5. Mid-pulse reset: assert RESET while LCD_E=1 → LCD_E=0, LCD_RW=1, READY=0 immediately, and the init sequence repeats from scenario 1.
